lfsr_sequencer: RTL and testbench
=================================

# lfsr_sequencer

Controller that owns the configuration and stepping port of the `lfsr` block. Accepts commands over a valid/ready interface, sequences the `lfsr` tap-load and seed-load strobes, and runs, halts and resumes the sequence. Optionally measures the sequence period. Sits between the top-level command source (pins or CPU) and `lfsr`. It never drives both `lfsr` reset strobes high together, because that combination is reserved for CPU mode at the top level.

## Interface
- `BITS`, default 5: LFSR width. Also the width of `data_o`, `cmd_data_i`, `lfsr_state_i` and `period_o`.
- `TICKS`, default 6250: clock cycles per LFSR step. Used only for stall detection.

Ports:
- `clk`  in  1: system clock. One clock; all logic on its rising edge.
- `reset_n_i`  in  1: reset, asynchronous and active-low.
- `cmd_valid_i`  in  1: command valid.
- `cmd_ready_o`  out  1: command ready.
- `cmd_op_i`  in  2: opcode.
  - 0 = LOAD_TAPS
  - 1 = LOAD_SEED
  - 2 = RUN
  - 3 = HALT
- `cmd_data_i`  in  BITS: taps or seed value for load commands.
- `lfsr_state_i`  in  BITS: connected to `lfsr.state_o`.
- `reset_lfsr_o`  out  1: connected to `lfsr.reset_lfsr_i`.
- `reset_taps_o`  out  1: connected to `lfsr.reset_taps_i`.
- `data_o`  out  BITS: connected to `lfsr.initial_state_i` and `lfsr.taps_i`.
- `running_o`  out  1: high in RUN.
- `period_valid_o`  out  1: period measurement done (sticky).
- `period_o`  out  BITS: measured period. 0 means stalled or non-returning.

## Operation
- States: IDLE, LOAD_T, LOAD_S, RUN, HALT.
- IDLE and HALT are frozen states: `reset_lfsr_o`=1 and `data_o`=`hold_q`, so the LFSR holds.
  - IDLE: `hold_q` = `seed_q`.
  - HALT: `hold_q` = the state captured on entry to HALT.
- RUN: `reset_lfsr_o`=0, `reset_taps_o`=0, `data_o`=`seed_q`. The LFSR free-runs.
- Command acceptance: on `cmd_valid_i & cmd_ready_o`. `cmd_ready_o`=1 in IDLE, RUN and HALT; 0 in LOAD_T and LOAD_S.
- LOAD_TAPS:
  - Enter LOAD_T for 2 cycles with `reset_taps_o`=1, `reset_lfsr_o`=0, `data_o`=`cmd_data_i` (latched on acceptance).
  - Then return to the state it was accepted from. If returning to RUN, restart measurement.
- LOAD_SEED:
  - `seed_q` <= `cmd_data_i`.
  - Enter LOAD_S for 2 cycles with `reset_lfsr_o`=1, `data_o`=`cmd_data_i`.
  - Then return to the originating state. HALT or IDLE set `hold_q` to the new seed; RUN restarts measurement.
- RUN command from IDLE or HALT:
  - `ref_q` <= `hold_q`, `prev_q` <= `hold_q`, step count <= 0, `period_valid_o` <= 0.
  - Enter RUN.
  - RUN while already in RUN is a no-op.
- HALT command from RUN:
  - `hold_q` <= `lfsr_state_i`.
  - Enter HALT; the LFSR freezes on that value.
  - HALT from IDLE or HALT is a no-op.
- Invariant: `reset_lfsr_o & reset_taps_o` is never 1.
- Period measurement, RUN only:
  - A step is any cycle where `lfsr_state_i != prev_q`; `prev_q` tracks `lfsr_state_i` every cycle.
  - On a step, `cnt` += 1.
  - If a step lands on `lfsr_state_i == ref_q`: `period_o` <= `cnt`+1 and `period_valid_o` <= 1.
  - If `cnt` reaches 2^BITS−1 with no match: `period_valid_o` <= 1 and `period_o` <= 0.
  - If no step occurs for 2·TICKS consecutive cycles: `period_valid_o` <= 1 and `period_o` <= 0.
  - Once valid, the result holds until measurement restarts.

## Timing
- Reset values:
  - State IDLE; `seed_q` = `hold_q` = 1.
  - `reset_lfsr_o`=1, `reset_taps_o`=0, `data_o`=1.
  - `cmd_ready_o`=1, `running_o`=0, `period_valid_o`=0, `period_o`=0.
- Reset is asynchronous: every output takes its reset value immediately, including in the middle of a LOAD pulse.
- A command accepted at edge N drives its strobe from edge N onward. `cmd_ready_o` is low for edges N+1 and N+2 and high again after edge N+2.
- RUN and HALT take effect at the accepting edge: `running_o` and the strobes change at edge N.
- Counter widths: `cnt` is BITS bits; the stall counter is clog2(2·TICKS+1) bits. Neither counter wraps; each saturates at its terminal value.

## Configuration
- Macro `LFSR_SEQ_PERIOD_EN`.
- Defined: period measurement and stall detection are present, as described above.
- Undefined: `ref_q`, `cnt` and the stall counter are removed; `period_valid_o` and `period_o` are tied to 0. Command and strobe behaviour is unchanged.

## Test plan
- Reset: hold `reset_n_i`=0 → `reset_lfsr_o`=1, `reset_taps_o`=0, `data_o`=5'h01, `cmd_ready_o`=1, `period_valid_o`=0.
- LOAD_TAPS 5'h14, then LOAD_SEED 5'h01, then RUN, with TICKS=4 → `cmd_ready_o` low for 2 cycles after each load. After 31 steps, `period_valid_o`=1 and `period_o`=31.
- LOAD_TAPS 5'h00, then RUN with a frozen `lfsr_state_i` → after 2·TICKS cycles, `period_valid_o`=1 and `period_o`=0.
- HALT mid-RUN with state 5'h0B → `data_o`=5'h0B, `reset_lfsr_o`=1, `running_o`=0. On RUN, the sequence resumes from 5'h0B and `period_o` re-measures to 31.
- Assert `reset_n_i` low during the second LOAD_T cycle → `reset_taps_o`=0 in the same cycle, state IDLE, `data_o`=5'h01.
- 2000 random commands with random `cmd_valid_i` → `reset_lfsr_o & reset_taps_o` is never 1, and no command is accepted while `cmd_ready_o`=0.

Source files
------------

// File: rtl/lfsr_sequencer.sv
// Command sequencer for the lfsr block: loads taps/seed, runs, halts and resumes it.
// Optional period measurement and stall detection are enabled by defining LFSR_SEQ_PERIOD_EN.
module lfsr_sequencer #(
  parameter int BITS  = 5,
  parameter int TICKS = 6250
) (
  input  logic            clk,
  input  logic            reset_n_i,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic [1:0]      cmd_op_i,
  input  logic [BITS-1:0] cmd_data_i,
  input  logic [BITS-1:0] lfsr_state_i,
  output logic            reset_lfsr_o,
  output logic            reset_taps_o,
  output logic [BITS-1:0] data_o,
  output logic            running_o,
  output logic            period_valid_o,
  output logic [BITS-1:0] period_o
);

  localparam logic [1:0] OP_LOAD_TAPS = 2'd0;
  localparam logic [1:0] OP_LOAD_SEED = 2'd1;
  localparam logic [1:0] OP_RUN       = 2'd2;
  localparam logic [1:0] OP_HALT      = 2'd3;

  typedef enum logic [2:0] {S_IDLE, S_LOAD_T, S_LOAD_S, S_RUN, S_HALT} state_t;

  state_t          state;
  state_t          ret_state;
  logic            ld_phase;
  logic [BITS-1:0] seed_q;
  logic [BITS-1:0] hold_q;
  logic            accept;

  assign accept = cmd_valid_i & cmd_ready_o;

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state        <= S_IDLE;
      ret_state    <= S_IDLE;
      ld_phase     <= 1'b0;
      seed_q       <= BITS'(1);
      hold_q       <= BITS'(1);
      reset_lfsr_o <= 1'b1;
      reset_taps_o <= 1'b0;
      data_o       <= BITS'(1);
      cmd_ready_o  <= 1'b1;
      running_o    <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_RUN, S_HALT: begin
          if (accept) begin
            case (cmd_op_i)
              OP_LOAD_TAPS: begin
                state        <= S_LOAD_T;
                ret_state    <= state;
                ld_phase     <= 1'b0;
                reset_taps_o <= 1'b1;
                reset_lfsr_o <= 1'b0;
                data_o       <= cmd_data_i;
                cmd_ready_o  <= 1'b0;
                running_o    <= 1'b0;
              end
              OP_LOAD_SEED: begin
                state        <= S_LOAD_S;
                ret_state    <= state;
                ld_phase     <= 1'b0;
                seed_q       <= cmd_data_i;
                reset_taps_o <= 1'b0;
                reset_lfsr_o <= 1'b1;
                data_o       <= cmd_data_i;
                cmd_ready_o  <= 1'b0;
                running_o    <= 1'b0;
              end
              OP_RUN: begin
                if (state != S_RUN) begin
                  state        <= S_RUN;
                  reset_lfsr_o <= 1'b0;
                  data_o       <= seed_q;
                  running_o    <= 1'b1;
                end
              end
              OP_HALT: begin
                if (state == S_RUN) begin
                  state        <= S_HALT;
                  hold_q       <= lfsr_state_i;
                  reset_lfsr_o <= 1'b1;
                  data_o       <= lfsr_state_i;
                  running_o    <= 1'b0;
                end
              end
              default: ;
            endcase
          end
        end
        S_LOAD_T, S_LOAD_S: begin
          if (!ld_phase) begin
            ld_phase <= 1'b1;
          end else begin
            ld_phase     <= 1'b0;
            state        <= ret_state;
            cmd_ready_o  <= 1'b1;
            reset_taps_o <= 1'b0;
            if (ret_state == S_RUN) begin
              reset_lfsr_o <= 1'b0;
              data_o       <= seed_q;
              running_o    <= 1'b1;
            end else begin
              // A frozen state freezes on the freshly loaded seed, or keeps its old hold value after a taps load.
              reset_lfsr_o <= 1'b1;
              if (state == S_LOAD_S) begin
                hold_q <= seed_q;
                data_o <= seed_q;
              end else begin
                data_o <= hold_q;
              end
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef LFSR_SEQ_PERIOD_EN
  localparam int              STALL_N  = 2 * TICKS;
  localparam int              STALL_W  = $clog2(STALL_N + 1);
  localparam logic [BITS-1:0] CNT_LAST = '1;

  logic [BITS-1:0]    ref_q;
  logic [BITS-1:0]    prev_q;
  logic [BITS-1:0]    cnt;
  logic [STALL_W-1:0] stall;
  logic               start_run;
  logic               restart_run;
  logic               step;

  assign start_run   = accept && (cmd_op_i == OP_RUN) && (state == S_IDLE || state == S_HALT);
  assign restart_run = (state == S_LOAD_T || state == S_LOAD_S) && ld_phase && (ret_state == S_RUN);
  assign step        = (lfsr_state_i != prev_q);

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ref_q          <= '0;
      prev_q         <= '0;
      cnt            <= '0;
      stall          <= '0;
      period_valid_o <= 1'b0;
      period_o       <= '0;
    end else if (start_run || restart_run) begin
      // Entering RUN from a freeze starts at hold_q; a load inside RUN restarts from the live state.
      ref_q          <= start_run ? hold_q : lfsr_state_i;
      prev_q         <= start_run ? hold_q : lfsr_state_i;
      cnt            <= '0;
      stall          <= '0;
      period_valid_o <= 1'b0;
      period_o       <= '0;
    end else if (state == S_RUN) begin
      prev_q <= lfsr_state_i;
      if (!period_valid_o) begin
        if (step) begin
          stall <= '0;
          if (cnt != CNT_LAST) cnt <= cnt + BITS'(1);
          if (lfsr_state_i == ref_q) begin
            period_o       <= cnt + BITS'(1);
            period_valid_o <= 1'b1;
          end else if (cnt == CNT_LAST - BITS'(1)) begin
            period_o       <= '0;
            period_valid_o <= 1'b1;
          end
        end else begin
          if (stall != STALL_W'(STALL_N)) stall <= stall + STALL_W'(1);
          if (stall == STALL_W'(STALL_N - 1)) begin
            period_o       <= '0;
            period_valid_o <= 1'b1;
          end
        end
      end
    end
  end
`else
  assign period_valid_o = 1'b0;
  assign period_o       = '0;

  // TICKS only sizes the stall timeout, which is compiled out here.
  if (TICKS < 1) begin : g_ticks_unused
  end
`endif

endmodule

// File: tb/tb_lfsr_sequencer.sv
// Self-checking bench for lfsr_sequencer with a behavioural lfsr and a command-level reference model.
// Period checks apply when LFSR_SEQ_PERIOD_EN is defined; otherwise the period outputs must stay 0.
module tb_lfsr_sequencer;
  localparam int BITS  = 5;
  localparam int TICKS = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [1:0]      cmd_op;
  logic [BITS-1:0] cmd_data;
  logic [BITS-1:0] lfsr_state;
  logic            reset_lfsr;
  logic            reset_taps;
  logic [BITS-1:0] data;
  logic            running;
  logic            period_valid;
  logic [BITS-1:0] period;

  int checks = 0;
  int errors = 0;

  // Command-level reference: mode 0 idle, 1 run, 2 halt; load 1 taps, 2 seed; left = load cycles remaining.
  int              m_mode, m_left, m_load, m_ret;
  logic [BITS-1:0] m_seed, m_hold, m_ldata;

  lfsr_sequencer #(.BITS(BITS), .TICKS(TICKS)) dut (
    .clk(clk), .reset_n_i(rst_n), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_op_i(cmd_op), .cmd_data_i(cmd_data), .lfsr_state_i(lfsr_state),
    .reset_lfsr_o(reset_lfsr), .reset_taps_o(reset_taps), .data_o(data),
    .running_o(running), .period_valid_o(period_valid), .period_o(period)
  );

  always #5 clk = ~clk;

  function automatic logic [BITS-1:0] lfsr_next(input logic [BITS-1:0] s, input logic [BITS-1:0] t);
    return {s[BITS-2:0], ^(s & t)};
  endfunction

  // Steps from start until it comes back; a fixed point or no return within 2^BITS-1 steps means 0.
  function automatic logic [BITS-1:0] ref_period(input logic [BITS-1:0] start, input logic [BITS-1:0] t);
    logic [BITS-1:0] s, n;
    s = start;
    for (int i = 1; i < (1 << BITS); i++) begin
      n = lfsr_next(s, t);
      if (n == s) return '0;
      s = n;
      if (s == start) return BITS'(i);
    end
    return '0;
  endfunction

  logic [BITS-1:0] l_state, l_taps;
  int              tick;
  assign lfsr_state = l_state;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l_state <= BITS'(1);
      l_taps  <= '0;
      tick    <= 0;
    end else begin
      if (reset_lfsr) l_state <= data;
      else if (reset_taps) l_taps <= data;
      else if (tick == TICKS - 1) l_state <= lfsr_next(l_state, l_taps);
      tick <= (tick == TICKS - 1) ? 0 : tick + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_left = 0; m_load = 0; m_ret = 0;
    m_seed = BITS'(1); m_hold = BITS'(1); m_ldata = '0;
  endtask

  task automatic check_outputs();
    logic            e_rl, e_rt;
    logic [BITS-1:0] e_data;
    if (m_left > 0) begin
      e_rl = (m_load == 2); e_rt = (m_load == 1); e_data = m_ldata;
    end else if (m_mode == 1) begin
      e_rl = 1'b0; e_rt = 1'b0; e_data = m_seed;
    end else begin
      e_rl = 1'b1; e_rt = 1'b0; e_data = m_hold;
    end
    chk("reset_lfsr", reset_lfsr, e_rl);
    chk("reset_taps", reset_taps, e_rt);
    chk("data", data, e_data);
    chk("cmd_ready", cmd_ready, m_left == 0);
    chk("running", running, (m_left == 0) && (m_mode == 1));
    chk("strobe_exclusive", reset_lfsr & reset_taps, 1'b0);
`ifndef LFSR_SEQ_PERIOD_EN
    chk("period_valid_off", period_valid, 1'b0);
    chk("period_off", period, '0);
`endif
  endtask

  // One clock: drive at the falling edge, advance the reference on the rising edge, check 1 ns later.
  task automatic step(input logic v, input logic [1:0] op, input logic [BITS-1:0] d);
    logic            acc;
    logic [BITS-1:0] st;
    @(negedge clk);
    cmd_valid = v; cmd_op = op; cmd_data = d;
    acc = v && (m_left == 0);
    st  = lfsr_state;
    @(posedge clk);
    #1;
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        if (m_load == 2 && m_ret != 1) m_hold = m_seed;
        m_mode = m_ret;
        m_load = 0;
      end
    end else if (acc) begin
      case (op)
        2'd0: begin m_load = 1; m_left = 2; m_ldata = d; m_ret = m_mode; end
        2'd1: begin m_load = 2; m_left = 2; m_ldata = d; m_seed = d; m_ret = m_mode; end
        2'd2: m_mode = 1;
        default: if (m_mode == 1) begin m_hold = st; m_mode = 2; end
      endcase
    end
    check_outputs();
  endtask

  task automatic check_period(input string tag, input logic [BITS-1:0] exp);
`ifdef LFSR_SEQ_PERIOD_EN
    for (int i = 0; i < 400 && period_valid !== 1'b1; i++) step(1'b0, 2'd0, '0);
    chk({tag, "_valid"}, period_valid, 1'b1);
    chk(tag, period, exp);
`else
    for (int i = 0; i < 200; i++) step(1'b0, 2'd0, '0);
    chk({tag, "_valid_off"}, period_valid, 1'b0);
`endif
  endtask

  initial begin
    logic [BITS-1:0] exp_p;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_data = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_reset_lfsr", reset_lfsr, 1'b1);
    chk("rst_reset_taps", reset_taps, 1'b0);
    chk("rst_data", data, 5'h01);
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_running", running, 1'b0);
    chk("rst_period_valid", period_valid, 1'b0);
    chk("rst_period", period, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Taps 5'h14, seed 1, run to a full period.
    step(1'b1, 2'd0, 5'h14);
    chk("ready_low_taps", cmd_ready, 1'b0);
    step(1'b1, 2'd2, '0);
    step(1'b0, 2'd0, '0);
    step(1'b1, 2'd1, 5'h01);
    step(1'b0, 2'd0, '0);
    step(1'b0, 2'd0, '0);
    step(1'b1, 2'd2, '0);
    chk("running_after_run", running, 1'b1);
    exp_p = ref_period(5'h01, 5'h14);
    check_period("period_seed1", exp_p);

    // Halt on 5'h0B, then resume and re-measure.
    for (int i = 0; i < 300 && lfsr_state !== 5'h0B; i++) step(1'b0, 2'd0, '0);
    chk("reach_0b", lfsr_state, 5'h0B);
    step(1'b1, 2'd3, '0);
    chk("halt_data", data, 5'h0B);
    chk("halt_reset_lfsr", reset_lfsr, 1'b1);
    chk("halt_running", running, 1'b0);
    repeat (10) step(1'b0, 2'd0, '0);
    chk("halt_frozen", lfsr_state, 5'h0B);
    step(1'b1, 2'd2, '0);
    exp_p = ref_period(5'h0B, 5'h14);
    check_period("period_resume", exp_p);

    // Zero taps: the sequence dies and the stall timeout reports 0.
    step(1'b1, 2'd3, '0);
    exp_p = ref_period(m_hold, '0);
    step(1'b1, 2'd0, 5'h00);
    step(1'b0, 2'd0, '0);
    step(1'b0, 2'd0, '0);
    step(1'b1, 2'd2, '0);
    check_period("period_stall", exp_p);

    // Asynchronous reset during the second LOAD_T cycle.
    step(1'b1, 2'd3, '0);
    step(1'b1, 2'd0, 5'h14);
    step(1'b0, 2'd0, '0);
    chk("mid_load_taps_high", reset_taps, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_reset_taps", reset_taps, 1'b0);
    chk("mid_rst_reset_lfsr", reset_lfsr, 1'b1);
    chk("mid_rst_data", data, 5'h01);
    chk("mid_rst_ready", cmd_ready, 1'b1);
    chk("mid_rst_running", running, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Random command traffic against the reference.
    for (int i = 0; i < 2000; i++)
      step(1'(($urandom % 3) != 0), 2'($urandom_range(0, 3)), BITS'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
